// File: rtl/thermo_decoder.sv
// Streaming thermometer-code decoder with a one-entry registered output stage,
// running count accumulator and saturating malformed-code counter.
// Optional macro THERMO_DECODER_STRICT_EN: drop illegal codes instead of forwarding them.
module thermo_decoder #(
  parameter int WIDTH     = 2,
  parameter int OUT_WIDTH = $clog2(WIDTH + 1),
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_count,
  output logic                 out_error,
  input  logic                 acc_clear,
  output logic [ACC_WIDTH-1:0] acc_value,
  output logic [7:0]           err_count
);

  logic                 valid_q, valid_d;
  logic [OUT_WIDTH-1:0] count_q, count_d;
  logic                 error_q, error_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [7:0]           err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0]     data_g;
  logic [OUT_WIDTH-1:0] popcnt;
  logic                 illegal;
  logic                 accept;
  logic                 load;
  logic                 xfer;

  // Gate the data with in_valid so an X on an idle bus never reaches state.
  assign data_g   = in_valid ? in_data : '0;
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = valid_q && out_ready;

  // A legal code is contiguous ones from bit 0, so adding one clears every set bit.
  assign illegal  = |(data_g & (data_g + WIDTH'(1)));

`ifdef THERMO_DECODER_STRICT_EN
  assign load = accept && !illegal;
`else
  assign load = accept;
`endif

  always_comb begin
    // NOTE: assign every always_comb output a default first so no path infers a latch.
    popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcnt = popcnt + OUT_WIDTH'(data_g[i]);
    end
  end

  always_comb begin
    valid_d   = valid_q;
    count_d   = count_q;
    error_d   = error_q;
    acc_d     = acc_q;
    err_cnt_d = err_cnt_q;

    if (load) begin
      valid_d = 1'b1;
      count_d = popcnt;
`ifdef THERMO_DECODER_STRICT_EN
      error_d = 1'b0;
`else
      error_d = illegal;
`endif
    end else if (xfer) begin
      valid_d = 1'b0;
    end

    // Clear beats a coincident transfer; the transferred count is discarded.
    if (acc_clear) begin
      acc_d = '0;
    end else if (xfer) begin
      acc_d = acc_q + ACC_WIDTH'(count_q);
    end

    if (accept && illegal && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      count_q   <= '0;
      error_q   <= 1'b0;
      acc_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      count_q   <= count_d;
      error_q   <= error_d;
      acc_q     <= acc_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_count = count_q;
`ifdef THERMO_DECODER_STRICT_EN
  assign out_error = 1'b0;
`else
  assign out_error = error_q;
`endif
  assign acc_value = acc_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_thermo_decoder.sv
// Directed self-checking bench for thermo_decoder: a WIDTH=2 instance and a
// WIDTH=4/ACC_WIDTH=4 instance sharing clock and reset.
module tb_thermo_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=2 instance
  logic       a_in_valid = 1'b0, a_out_ready = 1'b0, a_acc_clear = 1'b0;
  logic [1:0] a_in_data = '0;
  logic       a_in_ready, a_out_valid, a_out_error;
  logic [1:0] a_out_count;
  logic [15:0] a_acc_value;
  logic [7:0] a_err_count;

  // WIDTH=4, ACC_WIDTH=4 instance
  logic       b_in_valid = 1'b0, b_out_ready = 1'b0, b_acc_clear = 1'b0;
  logic [3:0] b_in_data = '0;
  logic       b_in_ready, b_out_valid, b_out_error;
  logic [2:0] b_out_count;
  logic [3:0] b_acc_value;
  logic [7:0] b_err_count;

  thermo_decoder #(.WIDTH(2), .ACC_WIDTH(16)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_count(a_out_count), .out_error(a_out_error),
    .acc_clear(a_acc_clear), .acc_value(a_acc_value), .err_count(a_err_count)
  );

  thermo_decoder #(.WIDTH(4), .ACC_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_count(b_out_count), .out_error(b_out_error),
    .acc_clear(b_acc_clear), .acc_value(b_acc_value), .err_count(b_err_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_acc;
  logic [1:0] sweep_data [3] = '{2'b00, 2'b01, 2'b11};

  initial begin
    // Reset and idle
    #2;
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_in_ready",  32'(a_in_ready),  32'd1);
    check("rst_out_count", 32'(a_out_count), 32'd0);
    check("rst_out_error", 32'(a_out_error), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_out_valid", 32'(a_out_valid), 32'd0);
    check("idle_in_ready",  32'(a_in_ready),  32'd1);
    check("idle_acc",       32'(a_acc_value), 32'd0);
    check("idle_err",       32'(a_err_count), 32'd0);

    // Legal sweep 00,01,11 with out_ready=1
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_data = sweep_data[i];
      tick();
      check("sweep_valid", 32'(a_out_valid), 32'd1);
      check("sweep_count", 32'(a_out_count), 32'(i));
      check("sweep_error", 32'(a_out_error), 32'd0);
    end
    a_in_valid = 1'b0;
    a_in_data  = 2'bxx;
    tick();
    check("sweep_drain_valid", 32'(a_out_valid), 32'd0);
    check("sweep_acc",         32'(a_acc_value), 32'd3);
    check("hold_count_idle",   32'(a_out_count), 32'd2);
    exp_acc = 3;

    // Illegal code 10
    a_in_valid  = 1'b1;
    a_in_data   = 2'b10;
    a_out_ready = 1'b0;
    tick();
    a_in_valid = 1'b0;
    check("illegal_err_count", 32'(a_err_count), 32'd1);
`ifdef THERMO_DECODER_STRICT_EN
    check("illegal_dropped", 32'(a_out_valid), 32'd0);
`else
    check("illegal_valid", 32'(a_out_valid), 32'd1);
    check("illegal_count", 32'(a_out_count), 32'd1);
    check("illegal_error", 32'(a_out_error), 32'd1);
    exp_acc = exp_acc + 1;
`endif
    a_out_ready = 1'b1;
    tick();
    check("illegal_acc", 32'(a_acc_value), 32'(exp_acc));

    // Clear with no transfer
    a_acc_clear = 1'b1;
    tick();
    a_acc_clear = 1'b0;
    check("clear_acc", 32'(a_acc_value), 32'd0);
    check("clear_keeps_err", 32'(a_err_count), 32'd1);

    // Backpressure: load 11, stall 3 cycles with 01 offered
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 2'b11;
    tick();
    a_in_data = 2'b01;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 32'(a_in_ready),  32'd0);
      check("bp_count",    32'(a_out_count), 32'd2);
      check("bp_valid",    32'(a_out_valid), 32'd1);
      check("bp_acc",      32'(a_acc_value), 32'd0);
      tick();
    end
    a_out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(a_in_ready), 32'd1);
    tick();
    a_in_valid = 1'b0;
    check("bp_refill_count", 32'(a_out_count), 32'd1);
    check("bp_refill_valid", 32'(a_out_valid), 32'd1);
    check("bp_acc_first",    32'(a_acc_value), 32'd2);
    tick();
    check("bp_acc_second",   32'(a_acc_value), 32'd3);
    check("bp_drain_valid",  32'(a_out_valid), 32'd0);

    // WIDTH=4 accumulator wrap, clear wins on 5th transfer
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_data   = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("w4_count", 32'(b_out_count), 32'd4);
      if (i > 0) check("w4_acc", 32'(b_acc_value), 32'((4 * i) % 16));
    end
    b_in_valid  = 1'b0;
    b_acc_clear = 1'b1;
    tick();
    b_acc_clear = 1'b0;
    check("w4_clear_wins", 32'(b_acc_value), 32'd0);
    check("w4_drain_valid", 32'(b_out_valid), 32'd0);

    // 300 illegal codes: err_count saturates
    b_in_valid = 1'b1;
    b_in_data  = 4'b0101;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 1) begin
`ifdef THERMO_DECODER_STRICT_EN
        check("w4_ill_dropped", 32'(b_out_valid), 32'd0);
`else
        check("w4_ill_count", 32'(b_out_count), 32'd2);
        check("w4_ill_error", 32'(b_out_error), 32'd1);
`endif
      end
      if (i == 254) check("sat_254", 32'(b_err_count), 32'd254);
      if (i == 255) check("sat_255", 32'(b_err_count), 32'd255);
    end
    check("sat_hold", 32'(b_err_count), 32'd255);
`ifndef THERMO_DECODER_STRICT_EN
    check("pre_rst_valid", 32'(b_out_valid), 32'd1);
`endif

    // Async reset mid-stream, away from the clock edge
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(b_out_valid), 32'd0);
    check("arst_err",   32'(b_err_count), 32'd0);
    check("arst_acc",   32'(b_acc_value), 32'd0);
    check("arst_ready", 32'(b_in_ready),  32'd1);
    b_in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_valid", 32'(b_out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
